io_tape_input_ctrl: RTL and testbench



---
 rtl/io_pkg.sv | 19 +
 rtl/io_digit_serializer.sv | 60 ++++++
 rtl/io_tape_input_ctrl.sv | 163 ++++++++++++++++
 tb/tb_io_tape_input_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared word/character geometry and tape-input FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int WORD_BITS = 30;
    localparam int DIGIT_W   = 4;
    localparam int CNT_W     = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/io_digit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : io_digit_serializer
// Description : Holds one tape character and tracks which bit is on the wire.
// Revision    : 1.0 - initial release
// ============================================================================
module io_digit_serializer #(
    parameter int DIGIT_W = io_pkg::DIGIT_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_data,
    input  logic               i_advance,
    output logic               o_next_bit,
    output logic               o_last
);
    import io_pkg::*;

    localparam int IDX_W = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGIT_W - 1);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            digit_q <= '0;
            idx_q   <= '0;
        end else begin
            digit_q <= digit_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        digit_d = digit_q;
        idx_d   = idx_q;
        if (i_load) begin
            digit_d = i_load_data;
            idx_d   = '0;
        end else if (i_advance) begin
            idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Bit that follows the current one (MSB-first); wraps harmlessly on the last bit.
    always_comb begin
        o_next_bit = 1'b0;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (idx_q == IDX_W'(i)) begin
                o_next_bit = digit_q[(2 * DIGIT_W - 2 - i) % DIGIT_W];
            end
        end
    end

    assign o_last = (idx_q == C_IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/io_tape_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_tape_input_ctrl
// Description : Tape-character to C-register serial feeder (MSB-first).
//               Optional odd-parity check enabled by IO_TAPE_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module io_tape_input_ctrl #(
    parameter int WORD_BITS = io_pkg::WORD_BITS,
    parameter int DIGIT_W   = io_pkg::DIGIT_W,
    parameter int CNT_W     = io_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               tape_valid,
    input  logic [DIGIT_W-1:0] tape_data,
    output logic               tape_ready,
    input  logic               shift_ready,
    output logic               shift_valid,
    output logic               io_input_data,
    output logic               busy,
    output logic               done,
`ifdef IO_TAPE_PARITY_EN
    input  logic               tape_parity,
    output logic               parity_err,
`endif
    output logic [CNT_W-1:0]   bit_count
);
    import io_pkg::*;

    localparam logic [CNT_W-1:0] C_WORD_BITS = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] C_WORD_LAST = CNT_W'(WORD_BITS - 1);

    logic [1:0]       state_q, state_d;
    logic             shift_valid_q, shift_valid_d;
    logic             io_input_data_q, io_input_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    logic w_char_ok;
    logic w_start_acc;
    logic w_fetch_hs;
    logic w_ser_load;
    logic w_shift_acc;
    logic w_word_last;
    logic w_ser_next_bit;
    logic w_ser_last;

`ifdef IO_TAPE_PARITY_EN
    logic parity_err_q, parity_err_d;
    // tape_parity flags an odd number of ones in the character.
    assign w_char_ok = (tape_parity == ^tape_data);
`else
    assign w_char_ok = 1'b1;
`endif

    assign w_start_acc = (state_q == ST_IDLE)  && start && !abort;
    assign w_fetch_hs  = (state_q == ST_FETCH) && tape_valid && !abort;
    assign w_ser_load  = w_fetch_hs && w_char_ok;
    assign w_shift_acc = (state_q == ST_SHIFT) && shift_valid_q && shift_ready && !abort;
    assign w_word_last = (bit_count_q == C_WORD_LAST);

    io_digit_serializer #(
        .DIGIT_W (DIGIT_W)
    ) u_ser (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_ser_load),
        .i_load_data (tape_data),
        .i_advance   (w_shift_acc),
        .o_next_bit  (w_ser_next_bit),
        .o_last      (w_ser_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_FETCH;
                ST_FETCH: if (tape_valid) state_d = w_char_ok ? ST_SHIFT : ST_DONE;
                ST_SHIFT: begin
                    if (w_shift_acc) begin
                        if (w_word_last)     state_d = ST_DONE;
                        else if (w_ser_last) state_d = ST_FETCH;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tape_ready    = (state_q == ST_FETCH);
        shift_valid_d = (state_d == ST_SHIFT);
        done_d        = (state_d == ST_DONE);

        busy_d = busy_q;
        if (abort || state_q == ST_DONE) busy_d = 1'b0;
        else if (w_start_acc)            busy_d = 1'b1;

        // The presented bit only moves on a load or an accepted shift.
        io_input_data_d = 1'b0;
        if (w_ser_load)                             io_input_data_d = tape_data[DIGIT_W-1];
        else if (w_shift_acc && state_d == ST_SHIFT) io_input_data_d = w_ser_next_bit;
        else if (state_d == ST_SHIFT)               io_input_data_d = io_input_data_q;

        bit_count_d = bit_count_q;
        if (w_start_acc)                                   bit_count_d = '0;
        else if (w_shift_acc && bit_count_q != C_WORD_BITS) bit_count_d = bit_count_q + 1'b1;
    end

`ifdef IO_TAPE_PARITY_EN
    always_comb begin
        parity_err_d = parity_err_q;
        if (w_start_acc)                   parity_err_d = 1'b0;
        else if (w_fetch_hs && !w_char_ok) parity_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) parity_err_q <= 1'b0;
        else         parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_valid_q   <= 1'b0;
            io_input_data_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            bit_count_q     <= '0;
        end else begin
            shift_valid_q   <= shift_valid_d;
            io_input_data_q <= io_input_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            bit_count_q     <= bit_count_d;
        end
    end

    assign shift_valid   = shift_valid_q;
    assign io_input_data = io_input_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_count     = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_io_tape_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_tape_input_ctrl
// Description : Directed self-checking bench for io_tape_input_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_tape_input_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       abort;
    logic       tape_valid;
    logic [3:0] tape_data;
    logic       tape_ready;
    logic       shift_ready;
    logic       shift_valid;
    logic       io_input_data;
    logic       busy;
    logic       done;
    logic [4:0] bit_count;
`ifdef IO_TAPE_PARITY_EN
    logic       tape_parity;
    logic       parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  chars [8] = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h3, 4'hC, 4'h9, 4'h6};
    logic [29:0] word;
    int          nbits;
    int          n_hs;
    int          n_done;

    always #5 clk = ~clk;

    io_tape_input_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .abort         (abort),
        .tape_valid    (tape_valid),
        .tape_data     (tape_data),
        .tape_ready    (tape_ready),
        .shift_ready   (shift_ready),
        .shift_valid   (shift_valid),
        .io_input_data (io_input_data),
        .busy          (busy),
        .done          (done),
`ifdef IO_TAPE_PARITY_EN
        .tape_parity   (tape_parity),
        .parity_err    (parity_err),
`endif
        .bit_count     (bit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; leaves the DUT in FETCH.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feeds characters and collects bits. Stops on done, or once stop_bits
    // shifts are committed (returns just after that edge).
    task automatic stream(input int stall_at, input int starve_char, input int stop_bits);
        int   ci          = 0;
        int   stall_left  = 5;
        int   starve_left = 10;
        bit   hs_prev     = 1'b0;
        bit   fin         = 1'b0;
        bit   stall_seen  = 1'b0;
        bit   starve_on   = 1'b0;
        logic held        = 1'b0;
        word   = '0;
        nbits  = 0;
        n_hs   = 0;
        n_done = 0;
        tape_data   = chars[0];
        tape_valid  = !(starve_char == 0);
        shift_ready = 1'b1;
`ifdef IO_TAPE_PARITY_EN
        tape_parity = ^tape_data;
`endif
        for (int guard = 0; guard < 400; guard++) begin
            @(negedge clk);
            if (hs_prev) chk("hs_to_shift_valid", shift_valid, 1);
            hs_prev = tape_ready && tape_valid;
            if (hs_prev) n_hs++;
            if (done) begin
                n_done++;
                fin = 1'b1;
            end
            if (shift_valid && shift_ready) begin
                if (nbits < 30) word[29-nbits] = io_input_data;
                nbits++;
            end
            if (!shift_ready) begin
                chk("stall_valid_high", shift_valid, 1);
                if (stall_seen) chk("stall_data_hold", io_input_data, held);
                held       = io_input_data;
                stall_seen = 1'b1;
                stall_left--;
            end
            if (!tape_valid && (tape_ready || starve_on)) begin
                starve_on = 1'b1;
                chk("starve_tape_ready", tape_ready, 1);
                chk("starve_no_shift", shift_valid, 0);
                chk("starve_busy", busy, 1);
                starve_left--;
            end
            if (fin || nbits == stop_bits) break;
            @(posedge clk); #1;
            if (hs_prev) ci++;
            tape_data   = (ci < 8) ? chars[ci] : 4'h0;
            tape_valid  = !(ci == starve_char && starve_left > 0);
            shift_ready = !(nbits == stall_at && stall_left > 0);
`ifdef IO_TAPE_PARITY_EN
            tape_parity = ^tape_data;
`endif
        end
        if (!fin && nbits != stop_bits) chk("stream_finished", fin, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        tape_valid  = 1'b0;
        tape_data   = 4'h0;
        shift_ready = 1'b0;
`ifdef IO_TAPE_PARITY_EN
        tape_parity = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_shift_valid", shift_valid, 0);
        chk("rst_tape_ready", tape_ready, 0);
        chk("rst_data", io_input_data, 0);
        chk("rst_bit_count", bit_count, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Full-speed word: 30 MSB-first bits of A5F03C96, low 2 bits of 6 dropped.
        pulse_start();
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_tape_ready", tape_ready, 1);
        chk("start_bit_count", bit_count, 0);
        @(posedge clk); #1;
        stream(-1, -1, -1);
        tape_valid = 1'b0;
        chk("w1_word", word, 30'h297C0F25);
        chk("w1_nbits", nbits, 30);
        chk("w1_handshakes", n_hs, 8);
        chk("w1_done_pulses", n_done, 1);
        @(negedge clk);
        chk("w1_done_low", done, 0);
        chk("w1_busy_low", busy, 0);
        chk("w1_bit_count", bit_count, 30);
        repeat (3) @(negedge clk);
        chk("w1_bit_count_held", bit_count, 30);
        chk("w1_no_extra_shift", shift_valid, 0);
        @(posedge clk); #1;

        // Stall on bit 13 and starve the sixth character.
        pulse_start();
        stream(13, 5, -1);
        tape_valid = 1'b0;
        chk("w2_word", word, 30'h297C0F25);
        chk("w2_nbits", nbits, 30);
        chk("w2_handshakes", n_hs, 8);
        chk("w2_done_pulses", n_done, 1);

        // Abort after bit 17 is committed.
        pulse_start();
        stream(-1, -1, 17);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_shift_valid", shift_valid, 0);
        chk("abort_tape_ready", tape_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_bit_count", bit_count, 17);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        @(posedge clk); #1;
        tape_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("restart_bit_count", bit_count, 0);
        chk("restart_busy", busy, 1);
        @(posedge clk); #1;
        stream(-1, -1, -1);
        tape_valid = 1'b0;
        chk("w3_word", word, 30'h297C0F25);
        chk("w3_done_pulses", n_done, 1);

        // Asynchronous reset mid-SHIFT while bit 5 (a one) is presented.
        @(posedge clk); #1;
        pulse_start();
        stream(-1, -1, 5);
        chk("pre_rst_data", io_input_data, 1);
        chk("pre_rst_count", bit_count, 5);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_shift_valid", shift_valid, 0);
        chk("arst_data", io_input_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bit_count", bit_count, 0);
        chk("arst_tape_ready", tape_ready, 0);
        chk("arst_done", done, 0);
        tape_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_shift_valid", shift_valid, 0);

`ifdef IO_TAPE_PARITY_EN
        @(posedge clk); #1;
        pulse_start();
        tape_data   = 4'h3;
        tape_parity = 1'b1;
        tape_valid  = 1'b1;
        @(posedge clk); #1;
        tape_valid = 1'b0;
        @(negedge clk);
        chk("par_err", parity_err, 1);
        chk("par_done", done, 1);
        chk("par_no_shift", shift_valid, 0);
        @(negedge clk);
        chk("par_done_low", done, 0);
        chk("par_busy_low", busy, 0);
        chk("par_err_sticky", parity_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
